// File: rtl/bp_pkg.sv
// Shared branch-prediction definitions.
// Used by branch_target_buffer, bp_sat_counter and the branch_prediction
// control unit: 2-bit direction-counter encodings, allocation values,
// next-PC mux select encodings and the small record carried down the
// prediction pipeline.
package bp_pkg;

  // 2-bit saturating direction counter; the MSB is the taken prediction.
  typedef enum logic [1:0] {
    SNT = 2'b00,  // strongly not taken
    WNT = 2'b01,  // weakly not taken
    WT  = 2'b10,  // weakly taken
    ST  = 2'b11   // strongly taken
  } cnt_e;

  // Counter value written when an entry is allocated.
  localparam logic [1:0] CNT_INIT_T  = WT;
  localparam logic [1:0] CNT_INIT_NT = WNT;

  // Next-PC select driven by branch_prediction.
  typedef enum logic [1:0] {
    MUX_PC_PLUS4    = 2'd0,  // sequential fetch
    MUX_TARGET_S1   = 2'd1,  // predicted target from the BTB
    MUX_TARGET_S4   = 2'd2,  // redirect to the resolved target
    MUX_PC_S4_PLUS4 = 2'd3   // redirect to the fall-through
  } mux_signal_e;

  // Prediction made at stage 1, carried to stage 4.
  typedef struct packed {
    logic hit;
    logic p;
  } pred_t;

endpackage

// File: rtl/branch_target_buffer_if.sv
// Prediction control interface between the branch_prediction unit (master)
// and the branch target buffer (slave).
//   pc_s1/hit_s1/p_s1/target_s1      : stage-1 lookup
//   stall/flush                      : prediction pipeline control
//   hit_s4/p_s4                      : stage-1 prediction seen at stage 4
//   pc_s4/target_s4/deviated_s4      : resolved branch at stage 4
//   write_rp/write_rt                : counter update / entry allocation
interface branch_target_buffer_if #(
  parameter int PC_W = 32
);
  logic [PC_W-1:0] pc_s1;
  logic            hit_s1;
  logic            p_s1;
  logic [PC_W-1:0] target_s1;
  logic            stall;
  logic            flush;
  logic            hit_s4;
  logic            p_s4;
  logic [PC_W-1:0] pc_s4;
  logic [PC_W-1:0] target_s4;
  logic            deviated_s4;
  logic            write_rp;
  logic            write_rt;

  modport slave (
    input  pc_s1, stall, flush, pc_s4, target_s4, deviated_s4, write_rp, write_rt,
    output hit_s1, p_s1, target_s1, hit_s4, p_s4
  );

  modport master (
    output pc_s1, stall, flush, pc_s4, target_s4, deviated_s4, write_rp, write_rt,
    input  hit_s1, p_s1, target_s1, hit_s4, p_s4
  );
endinterface

// File: rtl/bp_sat_counter.sv
// Combinational next value of a 2-bit saturating direction counter.
//   cnt_i   : current counter
//   taken_i : branch outcome (1 = taken, count up)
//   cnt_o   : next counter, saturating at SNT and ST
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       taken_i,
  output logic [1:0] cnt_o
);

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves cnt_o
    // unassigned; otherwise a latch is inferred.
    cnt_o = cnt_i;
    if (taken_i) begin
      if (cnt_i != ST) cnt_o = cnt_i + 2'd1;
    end else begin
      if (cnt_i != SNT) cnt_o = cnt_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Stage-1 lookup (hit_s1, p_s1, target_s1) is combinational from the table;
// the {hit, p} prediction is carried through s2..s4 registers to hit_s4 /
// p_s4. write_rt allocates and write_rp trains the entry indexed by pc_s4.
// Ports: clk, rst (async, active high), bus (branch_target_buffer_if.slave).
// Index = pc[IDX_W+1:2], tag = pc[PC_W-1:IDX_W+2].
// Optional macro BTB_BYPASS_EN: a lookup of the index being written in the
// same cycle returns the post-write entry instead of the stored one.
module branch_target_buffer
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 32
) (
  input logic clk,
  input logic rst,
  branch_target_buffer_if.slave bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic             valid_q [ENTRIES];
  logic             valid_d [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [TAG_W-1:0] tag_d   [ENTRIES];
  logic [PC_W-1:0]  tgt_q   [ENTRIES];
  logic [PC_W-1:0]  tgt_d   [ENTRIES];
  logic [1:0]       cnt_q   [ENTRIES];
  logic [1:0]       cnt_d   [ENTRIES];
  pred_t            pipe_q  [3];
  pred_t            pipe_d  [3];

  logic [IDX_W-1:0] idx_r, idx_w;
  logic [TAG_W-1:0] tag_r, tag_w;
  logic             hit_w;
  logic [1:0]       cnt_next;
  logic             hit_s1_w, p_s1_w;

  assign idx_r = bus.pc_s1[IDX_W+1:2];
  assign tag_r = bus.pc_s1[PC_W-1:IDX_W+2];
  assign idx_w = bus.pc_s4[IDX_W+1:2];
  assign tag_w = bus.pc_s4[PC_W-1:IDX_W+2];

  // Byte-offset bits never take part in indexing or tag compare.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.pc_s1[1:0], bus.pc_s4[1:0]};

  assign hit_w = valid_q[idx_w] && (tag_q[idx_w] == tag_w);

  bp_sat_counter u_sat (
    .cnt_i   (cnt_q[idx_w]),
    .taken_i (bus.deviated_s4),
    .cnt_o   (cnt_next)
  );

  // Table update; independent of stall/flush.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    if (bus.write_rt) begin
      valid_d[idx_w] = 1'b1;
      tag_d[idx_w]   = tag_w;
      tgt_d[idx_w]   = bus.target_s4;
      cnt_d[idx_w]   = bus.deviated_s4 ? CNT_INIT_T : CNT_INIT_NT;
    end else if (bus.write_rp && hit_w) begin
      cnt_d[idx_w] = cnt_next;
    end
  end

  // Lookup. The bypass build reads the post-write view of the table, which
  // equals the stored view for every index not being written this cycle.
  always_comb begin
`ifdef BTB_BYPASS_EN
    hit_s1_w = valid_d[idx_r] && (tag_d[idx_r] == tag_r) && !rst;
    p_s1_w   = hit_s1_w && cnt_d[idx_r][1];
    bus.target_s1 = hit_s1_w ? tgt_d[idx_r] : '0;
`else
    hit_s1_w = valid_q[idx_r] && (tag_q[idx_r] == tag_r) && !rst;
    p_s1_w   = hit_s1_w && cnt_q[idx_r][1];
    bus.target_s1 = hit_s1_w ? tgt_q[idx_r] : '0;
`endif
    bus.hit_s1 = hit_s1_w;
    bus.p_s1   = p_s1_w;
  end

  // Prediction pipeline s2..s4; flush wins over stall.
  always_comb begin
    pipe_d = pipe_q;
    if (bus.flush) begin
      pipe_d[0] = '0;
      pipe_d[1] = '0;
      pipe_d[2] = '0;
    end else if (!bus.stall) begin
      pipe_d[0] = '{hit: hit_s1_w, p: p_s1_w};
      pipe_d[1] = pipe_q[0];
      pipe_d[2] = pipe_q[1];
    end
  end

  assign bus.hit_s4 = pipe_q[2].hit;
  assign bus.p_s4   = pipe_q[2].p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the table is a flop array, not a RAM macro, so it can take the
      // async reset; clearing valid/cnt/target here is what makes a freshly
      // reset BTB miss everywhere.
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        cnt_q[i]   <= SNT;
      end
      for (int s = 0; s < 3; s++) pipe_q[s] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      pipe_q  <= pipe_d;
    end
  end

endmodule
